alu_arbiter: RTL and testbench

- Shares the single 32-bit ALU between two requesters, e.g. the main execute stage (port 0) and a branch/address helper (port 1).
- Accepts requests, arbitrates between them and registers the chosen operands.
- Drives the existing alu module from those registered operands and returns a registered result tagged with the requester id.
- One operation is in flight at a time.

---
 rtl/alu_arbiter_pkg.sv | 32 +++
 rtl/alu_arbiter_if.sv | 31 +++
 rtl/alu_arbiter_alu.sv | 29 ++
 rtl/alu_arbiter.sv | 132 +++++++++++++
 tb/tb_alu_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: ALU control codes,
// arbiter state encoding and the winner-selection helper.
package alu_arbiter_pkg;

  localparam int ALU_W = 32;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;
  localparam logic [3:0] ALU_XOR = 4'd13;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  // Under contention the round-robin mode favours the port that did not win last.
  function automatic logic pick_winner(input logic r0, input logic r1,
                                       input logic last_id, input logic fair);
    if (r0 && r1) begin
      return fair ? ~last_id : 1'b0;
    end else if (r1) begin
      return 1'b1;
    end else begin
      return 1'b0;
    end
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester/response bundle between the two ALU clients and the arbiter.
interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  logic             req0;
  logic [3:0]       ctl0;
  logic [ALU_W-1:0] a0;
  logic [ALU_W-1:0] b0;
  logic             gnt0;
  logic             req1;
  logic [3:0]       ctl1;
  logic [ALU_W-1:0] a1;
  logic [ALU_W-1:0] b1;
  logic             gnt1;
  logic             rsp_valid;
  logic             rsp_id;
  logic [ALU_W-1:0] rsp_out;
  logic             rsp_zero;
  logic             busy;

  modport master (
    output req0, ctl0, a0, b0, req1, ctl1, a1, b1,
    input  gnt0, gnt1, rsp_valid, rsp_id, rsp_out, rsp_zero, busy
  );

  modport slave (
    input  req0, ctl0, a0, b0, req1, ctl1, a1, b1,
    output gnt0, gnt1, rsp_valid, rsp_id, rsp_out, rsp_zero, busy
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// The existing 32-bit combinational ALU; undefined control codes yield zero.
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [3:0]       ctl,
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  output logic [ALU_W-1:0] out,
  output logic             zero
);

  // Operation select
  always_comb begin
    out = {ALU_W{1'b0}};
    case (ctl)
      ALU_AND: out = a & b;
      ALU_OR:  out = a | b;
      ALU_ADD: out = a + b;
      ALU_SUB: out = a - b;
      ALU_SLT: out = {{(ALU_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_NOR: out = ~(a | b);
      ALU_XOR: out = a ^ b;
      default: out = {ALU_W{1'b0}};
    endcase
  end

  assign zero = (out == {ALU_W{1'b0}});

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of the shared ALU: grants one request, registers
// its operands, and returns a registered result tagged with the owner id.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int FAIR   = 1,
  parameter int DATA_W = 32
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);

  if (DATA_W != ALU_W) begin : g_width_check
    $error("alu_arbiter: DATA_W must be 32 to match alu");
  end

  localparam logic FAIR_MODE = (FAIR != 0) ? 1'b1 : 1'b0;

  state_t           state;
  state_t           next_state;
  logic             winner;
  logic             load;
  logic             finish;
  logic             last_id;
  logic             owner;
  logic [3:0]       op_ctl;
  logic [ALU_W-1:0] op_a;
  logic [ALU_W-1:0] op_b;
  logic [ALU_W-1:0] alu_out;
  logic             alu_zero;
  logic             gnt0_q;
  logic             gnt1_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [ALU_W-1:0] rsp_out_q;
  logic             rsp_zero_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          next_state = EXEC;
        end else begin
          next_state = IDLE;
        end
      end
      EXEC:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Per-state control: accept a request in IDLE, retire the operation in EXEC
  always_comb begin
    winner = 1'b0;
    load   = 1'b0;
    finish = 1'b0;
    case (state)
      IDLE: begin
        winner = pick_winner(bus.req0, bus.req1, last_id, FAIR_MODE);
        load   = bus.req0 | bus.req1;
      end
      EXEC:    finish = 1'b1;
      default: begin
        load   = 1'b0;
        finish = 1'b0;
      end
    endcase
  end

  alu u_alu (
    .ctl  (op_ctl),
    .a    (op_a),
    .b    (op_b),
    .out  (alu_out),
    .zero (alu_zero)
  );

  // Operand capture, grant pulses and the registered response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_id     <= 1'b1;
      owner       <= 1'b0;
      op_ctl      <= 4'd0;
      op_a        <= {ALU_W{1'b0}};
      op_b        <= {ALU_W{1'b0}};
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_out_q   <= {ALU_W{1'b0}};
      rsp_zero_q  <= 1'b0;
    end else begin
      gnt0_q      <= load & ~winner;
      gnt1_q      <= load & winner;
      rsp_valid_q <= finish;
      if (load) begin
        last_id <= winner;
        owner   <= winner;
        op_ctl  <= winner ? bus.ctl1 : bus.ctl0;
        op_a    <= winner ? bus.a1 : bus.a0;
        op_b    <= winner ? bus.b1 : bus.b0;
      end
      // Response fields hold between pulses
      if (finish) begin
        rsp_out_q  <= alu_out;
        rsp_zero_q <= alu_zero;
        rsp_id_q   <= owner;
      end
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_out   = rsp_out_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a round-robin and a fixed-priority
// instance share stimulus; sel chooses which one is driven and observed.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req0, req1;
  logic [3:0]  ctl0, ctl1;
  logic [31:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, rsp_valid, rsp_id, rsp_zero, busy;
  logic [31:0] rsp_out;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  alu_arbiter_if if_f ();
  alu_arbiter_if if_x ();

  alu_arbiter #(.FAIR(1), .DATA_W(32)) dut_fair (.clk(clk), .rst(rst), .bus(if_f));
  alu_arbiter #(.FAIR(0), .DATA_W(32)) dut_fix  (.clk(clk), .rst(rst), .bus(if_x));

  assign if_f.req0 = req0 & ~sel;
  assign if_f.req1 = req1 & ~sel;
  assign if_x.req0 = req0 & sel;
  assign if_x.req1 = req1 & sel;
  assign if_f.ctl0 = ctl0;  assign if_x.ctl0 = ctl0;
  assign if_f.ctl1 = ctl1;  assign if_x.ctl1 = ctl1;
  assign if_f.a0   = a0;    assign if_x.a0   = a0;
  assign if_f.b0   = b0;    assign if_x.b0   = b0;
  assign if_f.a1   = a1;    assign if_x.a1   = a1;
  assign if_f.b1   = b1;    assign if_x.b1   = b1;

  assign gnt0      = sel ? if_x.gnt0      : if_f.gnt0;
  assign gnt1      = sel ? if_x.gnt1      : if_f.gnt1;
  assign rsp_valid = sel ? if_x.rsp_valid : if_f.rsp_valid;
  assign rsp_id    = sel ? if_x.rsp_id    : if_f.rsp_id;
  assign rsp_out   = sel ? if_x.rsp_out   : if_f.rsp_out;
  assign rsp_zero  = sel ? if_x.rsp_zero  : if_f.rsp_zero;
  assign busy      = sel ? if_x.busy      : if_f.busy;

  typedef struct {
    logic        port;
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;
    logic        zero;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (c)
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd12:   return ~(a | b);
      4'd13:   return a ^ b;
      4'd7:    return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic port, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b);
    if (port) begin
      req1 = 1'b1; ctl1 = c; a1 = a; b1 = b;
    end else begin
      req0 = 1'b1; ctl0 = c; a0 = a; b0 = b;
    end
  endtask

  task automatic reset_pulse();
    req0 = 1'b0;
    req1 = 1'b0;
    rst  = 1'b1;
    tick();
    rst  = 1'b0;
    tick();
  endtask

  // One isolated operation: grant one edge after the request, result one edge later
  task automatic single_op(input string tag, input logic port, input logic [3:0] c,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eo, input logic ez);
    present(port, c, a, b);
    tick();
    chk1({tag, " gnt0"}, gnt0, ~port);
    chk1({tag, " gnt1"}, gnt1, port);
    chk1({tag, " busy"}, busy, 1'b1);
    chk1({tag, " early valid"}, rsp_valid, 1'b0);
    req0 = 1'b0; req1 = 1'b0;
    a0 = ~a0; b0 = ~b0; a1 = ~a1; b1 = ~b1; ctl0 = ~ctl0; ctl1 = ~ctl1;
    tick();
    chk1({tag, " valid"}, rsp_valid, 1'b1);
    chk1({tag, " id"}, rsp_id, port);
    chk32({tag, " out"}, rsp_out, eo);
    chk1({tag, " zero"}, rsp_zero, ez);
    chk1({tag, " gnt cleared"}, gnt0 | gnt1, 1'b0);
    tick();
    chk1({tag, " valid pulse"}, rsp_valid, 1'b0);
    chk1({tag, " idle"}, busy, 1'b0);
    chk32({tag, " hold"}, rsp_out, eo);
  endtask

  // Both ports held; round-robin alternates from port 0, fixed priority serves port 0 only
  task automatic contention(input logic fixed);
    logic ep;
    sel = fixed;
    present(1'b0, 4'd1, 32'h0000_00F0, 32'h0000_000F);
    present(1'b1, 4'd13, 32'h0000_00FF, 32'h0000_000F);
    for (int k = 0; k < 4; k++) begin
      ep = fixed ? 1'b0 : k[0];
      tick();
      chk1("cont gnt0", gnt0, ~ep);
      chk1("cont gnt1", gnt1, ep);
      tick();
      chk1("cont valid", rsp_valid, 1'b1);
      chk1("cont id", rsp_id, ep);
      chk32("cont out", rsp_out, ep ? 32'h0000_00F0 : 32'h0000_00FF);
    end
    req0 = 1'b0;
    if (fixed) begin
      tick();
      chk1("fixed late gnt1", gnt1, 1'b1);
      req1 = 1'b0;
      tick();
      chk1("fixed late id", rsp_id, 1'b1);
      chk32("fixed late out", rsp_out, 32'h0000_00F0);
    end else begin
      req1 = 1'b0;
    end
    tick();
  endtask

  // Random requesters checked against a cycle-level reference of the arbitration rules
  task automatic random_run(input logic fixed, input int n);
    logic        m_exec;
    logic        m_last;
    logic        m_owner;
    logic        w;
    logic        eg0, eg1, ev;
    logic [31:0] m_out;
    m_exec = 1'b0; m_last = 1'b1; m_owner = 1'b0; m_out = 32'd0; w = 1'b0;
    sel = fixed;
    for (int cyc = 0; cyc < n; cyc++) begin
      eg0 = 1'b0; eg1 = 1'b0; ev = 1'b0;
      if (m_exec) begin
        ev = 1'b1;
        m_exec = 1'b0;
      end else if (req0 || req1) begin
        if (req0 && req1) w = fixed ? 1'b0 : ~m_last;
        else w = req1;
        m_owner = w;
        m_last  = w;
        m_exec  = 1'b1;
        m_out   = w ? alu_ref(ctl1, a1, b1) : alu_ref(ctl0, a0, b0);
        eg0 = ~w;
        eg1 = w;
      end
      tick();
      chk1("rnd gnt0", gnt0, eg0);
      chk1("rnd gnt1", gnt1, eg1);
      chk1("rnd valid", rsp_valid, ev);
      chk1("rnd busy", busy, m_exec);
      if (ev) begin
        chk1("rnd id", rsp_id, m_owner);
        chk32("rnd out", rsp_out, m_out);
        chk1("rnd zero", rsp_zero, m_out == 32'd0);
      end
      if (gnt0 || !req0) begin
        req0 = ($urandom_range(0, 2) != 0);
        ctl0 = 4'($urandom_range(0, 15));
        a0 = $urandom; b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
      end
      if (gnt1 || !req1) begin
        req1 = ($urandom_range(0, 2) != 0);
        ctl1 = 4'($urandom_range(0, 15));
        a1 = $urandom; b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b0, 4'd2,  32'd5,          32'd7,          32'd12,         1'b0};
    vecs[1]  = '{1'b1, 4'd6,  32'd5,          32'd5,          32'd0,          1'b1};
    vecs[2]  = '{1'b1, 4'd7,  32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0};
    vecs[3]  = '{1'b0, 4'd12, 32'd0,          32'd0,          32'hFFFF_FFFF,  1'b0};
    vecs[4]  = '{1'b0, 4'd0,  32'h0000_FF00,  32'h0000_0FF0,  32'h0000_0F00,  1'b0};
    vecs[5]  = '{1'b0, 4'd3,  32'd9,          32'd9,          32'd0,          1'b1};
    vecs[6]  = '{1'b1, 4'd13, 32'h0000_00FF,  32'h0000_000F,  32'h0000_00F0,  1'b0};
    vecs[7]  = '{1'b0, 4'd1,  32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF,  1'b0};
    vecs[8]  = '{1'b0, 4'd7,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b1};
    vecs[9]  = '{1'b1, 4'd6,  32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0};
    vecs[10] = '{1'b0, 4'd2,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};

    rst = 1'b1; sel = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    ctl0 = 4'd0; ctl1 = 4'd0;
    a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0;
    tick();
    tick();
    chk1("reset gnt0", gnt0, 1'b0);
    chk1("reset gnt1", gnt1, 1'b0);
    chk1("reset valid", rsp_valid, 1'b0);
    chk1("reset id", rsp_id, 1'b0);
    chk32("reset out", rsp_out, 32'd0);
    chk1("reset zero", rsp_zero, 1'b0);
    chk1("reset busy", busy, 1'b0);
    rst = 1'b0;
    tick();
    chk1("idle no grant", gnt0 | gnt1 | rsp_valid | busy, 1'b0);

    for (int i = 0; i < 11; i++) begin
      single_op($sformatf("vec%0d", i), vecs[i].port, vecs[i].ctl, vecs[i].a, vecs[i].b,
                vecs[i].out, vecs[i].zero);
    end

    present(1'b0, 4'd12, 32'd0, 32'd0);
    tick();
    chk1("b2b gnt a", gnt0, 1'b1);
    present(1'b0, 4'd0, 32'h0000_FF00, 32'h0000_0FF0);
    tick();
    chk1("b2b valid a", rsp_valid, 1'b1);
    chk32("b2b out a", rsp_out, 32'hFFFF_FFFF);
    chk1("b2b gap", gnt0, 1'b0);
    tick();
    chk1("b2b gnt b", gnt0, 1'b1);
    chk1("b2b no valid", rsp_valid, 1'b0);
    req0 = 1'b0;
    tick();
    chk1("b2b valid b", rsp_valid, 1'b1);
    chk32("b2b out b", rsp_out, 32'h0000_0F00);
    tick();

    present(1'b0, 4'd2, 32'd3, 32'd4);
    tick();
    chk1("midrst gnt", gnt0, 1'b1);
    chk1("midrst busy", busy, 1'b1);
    req0 = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk1("midrst gnt clr", gnt0, 1'b0);
    chk1("midrst busy clr", busy, 1'b0);
    chk1("midrst valid", rsp_valid, 1'b0);
    chk32("midrst out clr", rsp_out, 32'd0);
    tick();
    chk1("midrst no rsp", rsp_valid, 1'b0);
    rst = 1'b0;
    tick();
    chk1("midrst dropped", rsp_valid | busy, 1'b0);
    single_op("rerequest", 1'b0, 4'd2, 32'd3, 32'd4, 32'd7, 1'b0);

    reset_pulse();
    contention(1'b0);
    reset_pulse();
    contention(1'b1);

    reset_pulse();
    random_run(1'b0, 200);
    reset_pulse();
    random_run(1'b1, 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
